// File: rtl/program_loader.sv
// Byte-stream loader for the MIPS instruction memory: packs 4 bytes per word, writes words
// to ascending addresses from 0, and keeps the CPU held until the requested count is written.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH  = 64,
    parameter int unsigned ADDR_WIDTH    = 6,
    parameter int unsigned LITTLE_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    localparam logic [ADDR_WIDTH:0]   DepthW  = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);
    localparam logic [ADDR_WIDTH:0]   OneW    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] OneIdx  = ADDR_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [31:0]             shreg_q, shreg_d;
    logic                    ready_q, ready_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Outputs are registered, so each *_d is the value for the cycle spent in state_d.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        ready_d    = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        hold_d     = hold_q;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (word_count > DepthW) begin
                        error_d = 1'b1;
                    end else if (word_count == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        error_d = 1'b0;
                        hold_d  = 1'b0;
                    end else begin
                        state_d    = StCollect;
                        count_d    = word_count;
                        idx_d      = '0;
                        byte_cnt_d = '0;
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                        hold_d     = 1'b1;
                        ready_d    = 1'b1;
                    end
                end
            end
            StCollect: begin
                ready_d = 1'b1;
                if (byte_valid && ready_q) begin
                    if (LITTLE_ENDIAN != 0) begin
                        shreg_d = {byte_in, shreg_q[31:8]};
                    end else begin
                        shreg_d = {shreg_q[23:0], byte_in};
                    end
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                        ready_d = 1'b0;
                        we_d    = 1'b1;
                        addr_d  = idx_q;
                        data_d  = shreg_d;
                    end
                end
            end
            StWrite: begin
                if ({1'b0, idx_q} == count_q - OneW) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = StCollect;
                    idx_d   = idx_q + OneIdx;
                    ready_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign byte_ready       = ready_q;
    assign mem_write_enable = we_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = data_q;
    assign cpu_hold         = hold_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and randomized loads checked against a byte-to-word
// reference model; a second instance covers the little-endian packing.
module tb_program_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          cpu_hold;
    logic          done;
    logic          error;

    logic          start_le;
    logic [AW:0]   wc_le;
    logic [7:0]    byte_in_le;
    logic          valid_le;
    logic          ready_le;
    logic          we_le;
    logic [AW-1:0] addr_le;
    logic [31:0]   data_le;
    logic          hold_le;
    logic          done_le;
    logic          error_le;

    always #5 clk = ~clk;

    program_loader #(.MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(AW), .LITTLE_ENDIAN(0)) dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    program_loader #(.MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(AW), .LITTLE_ENDIAN(1)) dut_le (
        .clk(clk), .reset(reset), .start(start_le), .word_count(wc_le),
        .byte_in(byte_in_le), .byte_valid(valid_le), .byte_ready(ready_le),
        .mem_write_enable(we_le), .mem_address(addr_le),
        .mem_write_data(data_le), .cpu_hold(hold_le), .done(done_le), .error(error_le)
    );

    int ncmp = 0;
    int nerr = 0;
    int ready_in_write = 0;
    logic [7:0]    bytes_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];

    // Every write strobe seen on the big-endian instance, in order.
    always @(negedge clk) begin
        if (mem_write_enable) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_write_data);
            if (byte_ready) ready_in_write++;
        end
    end

    function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input bit le);
        return le ? {b3, b2, b1, b0} : {b0, b1, b2, b3};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_flags"}, {27'd0, byte_ready, mem_write_enable, cpu_hold, done, error},
              32'b00100);
        check({tag, "_addr"}, 32'(mem_address), 32'd0);
        check({tag, "_data"}, mem_write_data, 32'd0);
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic fill_random(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic do_start(input int wc);
        @(negedge clk);
        start = 1'b1;
        word_count = (AW + 1)'(wc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        budget = 0;
        while (!byte_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("byte_accept", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 0;
        while (!done && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        check("done", 32'(done), 32'd1);
        check("hold_released", 32'(cpu_hold), 32'd0);
    endtask

    task automatic compare_writes(input int n);
        check("write_count", wr_addr_q.size(), 32'(n));
        for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
            check("write_addr", 32'(wr_addr_q[k]), 32'(k));
            check("write_data", wr_data_q[k],
                  pack(bytes_q[4*k], bytes_q[4*k+1], bytes_q[4*k+2], bytes_q[4*k+3], 1'b0));
        end
    endtask

    task automatic run_load(input int wc, input int gmin, input int gmax);
        clear_writes();
        do_start(wc);
        check("load_hold", 32'(cpu_hold), 32'd1);
        check("load_not_done", 32'(done), 32'd0);
        for (int i = 0; i < 4 * wc; i++) send_byte(bytes_q[i], $urandom_range(gmin, gmax));
        wait_done();
        compare_writes(wc);
    endtask

    task automatic load_le(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] bb[4];
        bb = '{b0, b1, b2, b3};
        @(negedge clk);
        start_le = 1'b1;
        wc_le = 1;
        @(negedge clk);
        start_le = 1'b0;
        check("le_ready", 32'(ready_le), 32'd1);
        for (int i = 0; i < 4; i++) begin
            byte_in_le = bb[i];
            valid_le = 1'b1;
            @(negedge clk);
        end
        valid_le = 1'b0;
        check("le_we", 32'(we_le), 32'd1);
        check("le_addr", 32'(addr_le), 32'd0);
        check("le_data", data_le, pack(b0, b1, b2, b3, 1'b1));
        @(negedge clk);
        check("le_done", 32'(done_le), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        word_count = '0;
        byte_in = '0;
        byte_valid = 1'b0;
        start_le = 1'b0;
        wc_le = '0;
        byte_in_le = '0;
        valid_le = 1'b0;

        // Reset held, then idle
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("in_reset");
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("idle");
        end
        check("idle_writes", wr_addr_q.size(), 32'd0);

        // Single big-endian word with exact strobe/done timing
        bytes_q = '{8'h20, 8'h08, 8'h00, 8'h05};
        clear_writes();
        do_start(1);
        for (int i = 0; i < 4; i++) send_byte(bytes_q[i], 0);
        @(negedge clk);
        check("single_we", 32'(mem_write_enable), 32'd1);
        check("single_addr", 32'(mem_address), 32'd0);
        check("single_data", mem_write_data, 32'h20080005);
        @(negedge clk);
        check("single_done", 32'(done), 32'd1);
        check("single_hold", 32'(cpu_hold), 32'd0);
        check("single_we_off", 32'(mem_write_enable), 32'd0);
        compare_writes(1);

        // Stalled stream, 3 idle cycles before every byte
        bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(2, 3, 3);
        check("ready_in_write", 32'(ready_in_write), 32'd0);
        check("done_no_ready", 32'(byte_ready), 32'd0);

        // Little-endian instance
        load_le(8'h05, 8'h00, 8'h08, 8'h20);
        load_le(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Randomized loads
        for (int r = 0; r < 4; r++) begin
            int wc;
            wc = $urandom_range(1, 6);
            fill_random(4 * wc);
            run_load(wc, 0, 2);
        end
        check("ready_in_write_rand", 32'(ready_in_write), 32'd0);

        // Abort mid-load and restart
        fill_random(12);
        clear_writes();
        do_start(3);
        for (int i = 0; i < 6; i++) send_byte(bytes_q[i], 0);
        #2 reset = 1'b0;
        #1 check_reset_vals("abort");
        @(negedge clk);
        reset = 1'b1;
        fill_random(4);
        clear_writes();
        do_start(1);
        send_byte(bytes_q[0], 0);
        send_byte(bytes_q[1], 1);
        do_start(5);
        check("start_ignored_hold", 32'(cpu_hold), 32'd1);
        send_byte(bytes_q[2], 0);
        send_byte(bytes_q[3], 0);
        wait_done();
        compare_writes(1);

        // Bounds from a fresh IDLE
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_writes();
        do_start(DEPTH + 1);
        check("over_error", 32'(error), 32'd1);
        check("over_hold", 32'(cpu_hold), 32'd1);
        check("over_done", 32'(done), 32'd0);
        check("over_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("over_writes", wr_addr_q.size(), 32'd0);
        do_start(0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_error", 32'(error), 32'd0);
        check("zero_hold", 32'(cpu_hold), 32'd0);
        fill_random(4 * DEPTH);
        run_load(DEPTH, 0, 0);
        if (wr_addr_q.size() > 0) check("last_addr", 32'(wr_addr_q[$]), 32'(DEPTH - 1));
        check("full_error", 32'(error), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
